// File: rtl/pc_pkg.sv
// pc_pkg: operation codes shared between the control unit and pc_unit.
//   pc_op_t : 3-bit program-counter operation (codes 6-7 are reserved and
//             treated as HOLD by pc_unit).
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_INC    = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JUMP   = 3'd3,
    PC_CALL   = 3'd4,
    PC_RET    = 3'd5
  } pc_op_t;

endpackage

// File: rtl/pc_unit_return_stack.sv
// return_stack: circular LIFO of return addresses.
//   clk   : clock, all state changes on rising edge
//   reset : synchronous active-low; clears pointer and count (not contents)
//   push  : write wdata at top+1 and advance top (overwrites oldest if full)
//   pop   : retreat top (ignored when empty)
//   wdata : value to push
//   top   : entry at the top pointer
//   count : number of valid entries (0..DEPTH)
//   full  : count == DEPTH
//   empty : count == 0
module return_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW:0]      cnt_q, cnt_d;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign top   = mem_q[ptr_q];
  assign count = cnt_q;

  // A push while full wraps onto the oldest slot; count saturates at DEPTH.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; only pointer/count define validity.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[ptr_d] <= wdata;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with increment, relative branch, absolute jump
// and call/return through an internal circular return-address stack.
//   clk       : clock
//   reset     : synchronous active-low
//   stall     : freeze all state, ignore op
//   op        : pc_op_t operation code
//   offset    : signed branch displacement
//   target    : absolute jump/call destination
//   pc_out    : registered current PC
//   pc_next   : value pc_out takes at the next edge
//   depth     : valid return-stack entries
//   overflow  : sticky, CALL with stack full
//   underflow : sticky, RET with stack empty
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned          WIDTH        = 16,
  parameter int unsigned          INC          = 2,
  parameter logic [WIDTH-1:0]     RESET_VECTOR = '0,
  parameter int unsigned          STACK_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic [2:0]                    op,
  input  logic [WIDTH-1:0]              offset,
  input  logic [WIDTH-1:0]              target,
  output logic [WIDTH-1:0]              pc_out,
  output logic [WIDTH-1:0]              pc_next,
  output logic [$clog2(STACK_DEPTH):0]  depth,
  output logic                          overflow,
  output logic                          underflow
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full, stk_empty;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (pc_q + INC_W),
    .top   (stk_top),
    .count (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Priority: reset > stall > op; reserved codes fall to default (hold).
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (!reset) begin
      pc_d  = RESET_VECTOR;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (!stall) begin
      case (pc_op_t'(op))
        PC_INC:    pc_d = pc_q + INC_W;
        PC_BRANCH: pc_d = pc_q + offset;
        PC_JUMP:   pc_d = target;
        PC_CALL: begin
          push = 1'b1;
          pc_d = target;
          if (stk_full) ovf_d = 1'b1;
        end
        PC_RET: begin
          if (stk_empty) begin
            unf_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = stk_top;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc_out    = pc_q;
  assign pc_next   = pc_d;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  import pc_pkg::*;

  localparam logic [15:0] RV  = 16'h0000;
  localparam int unsigned SD  = 4;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [2:0]  op;
  logic [15:0] offset, target;
  logic [15:0] pc_out, pc_next;
  logic [2:0]  depth;
  logic        overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference state: PC, flags, and the return stack as a bounded queue
  // (back = most recent push; front dropped when capacity exceeded).
  logic [15:0] m_pc;
  logic        m_ovf, m_unf;
  logic [15:0] m_stk [$];

  always #5 clk = ~clk;

  pc_unit #(
    .WIDTH        (16),
    .INC          (2),
    .RESET_VECTOR (RV),
    .STACK_DEPTH  (SD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .op        (op),
    .offset    (offset),
    .target    (target),
    .pc_out    (pc_out),
    .pc_next   (pc_next),
    .depth     (depth),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, check pc_next before the edge,
  // then check the registered outputs after it.
  task automatic cyc(input logic rst, input logic stl, input logic [2:0] o,
                     input logic [15:0] off, input logic [15:0] tgt);
    logic [15:0] npc;
    logic        no, nu;
    reset = rst; stall = stl; op = o; offset = off; target = tgt;
    npc = m_pc; no = m_ovf; nu = m_unf;
    if (!rst) begin
      npc = RV; no = 1'b0; nu = 1'b0;
      m_stk.delete();
    end else if (!stl) begin
      case (o)
        3'd1: npc = m_pc + 16'd2;
        3'd2: npc = m_pc + off;
        3'd3: npc = tgt;
        3'd4: begin
          m_stk.push_back(m_pc + 16'd2);
          if (m_stk.size() > SD) begin
            void'(m_stk.pop_front());
            no = 1'b1;
          end
          npc = tgt;
        end
        3'd5: begin
          if (m_stk.size() == 0) nu = 1'b1;
          else npc = m_stk.pop_back();
        end
        default: ;
      endcase
    end
    #1;
    chk("pc_next", pc_next, npc);
    @(posedge clk);
    #1;
    m_pc = npc; m_ovf = no; m_unf = nu;
    chk("pc_out",    pc_out,                 m_pc);
    chk("depth",     {13'd0, depth},         16'(m_stk.size()));
    chk("overflow",  {15'd0, overflow},      {15'd0, m_ovf});
    chk("underflow", {15'd0, underflow},     {15'd0, m_unf});
  endtask

  task automatic run(input logic [2:0] o, input logic [15:0] off, input logic [15:0] tgt);
    cyc(1'b1, 1'b0, o, off, tgt);
  endtask

  initial begin
    m_pc = RV; m_ovf = 1'b0; m_unf = 1'b0;
    reset = 1'b0; stall = 1'b0; op = 3'd0; offset = '0; target = '0;
    @(posedge clk); #1;

    // Reset for two cycles with INC, then three increments.
    cyc(1'b0, 1'b0, PC_INC, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, PC_INC, 16'h0, 16'h0);
    chk("reset_pc", pc_out, 16'h0000);
    run(PC_INC, 16'h0, 16'h0); chk("inc1", pc_out, 16'h0002);
    run(PC_INC, 16'h0, 16'h0); chk("inc2", pc_out, 16'h0004);
    run(PC_INC, 16'h0, 16'h0); chk("inc3", pc_out, 16'h0006);

    // Branch wrapping below zero, then increment wrapping above max.
    run(PC_JUMP, 16'h0, 16'h0004);
    run(PC_BRANCH, 16'hFFFA, 16'h0); chk("branch_wrap", pc_out, 16'hFFFE);
    run(PC_INC, 16'h0, 16'h0);       chk("inc_wrap", pc_out, 16'h0000);
    run(PC_BRANCH, 16'h0000, 16'h0); chk("branch_zero", pc_out, 16'h0000);

    // Stall holds a pending JUMP for three cycles.
    run(PC_JUMP, 16'h0, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, PC_JUMP, 16'h0, 16'h1234);
      chk("stall_pc", pc_out, 16'h0010);
    end
    run(PC_JUMP, 16'h0, 16'h1234); chk("unstall", pc_out, 16'h1234);

    // Nested call/return.
    run(PC_JUMP, 16'h0, 16'h0100);
    run(PC_CALL, 16'h0, 16'h0200); chk("call1", pc_out, 16'h0200);
    run(PC_CALL, 16'h0, 16'h0300); chk("call2", pc_out, 16'h0300);
    run(PC_RET,  16'h0, 16'h0);    chk("ret1",  pc_out, 16'h0202);
    run(PC_RET,  16'h0, 16'h0);    chk("ret2",  pc_out, 16'h0102);

    // Overflow: five calls from 0x10..0x50 into a 4-deep stack.
    run(PC_JUMP, 16'h0, 16'h0010);
    for (int i = 0; i < 5; i++) run(PC_CALL, 16'h0, 16'((i + 2) * 16));
    chk("ovf_flag",  {15'd0, overflow}, 16'h0001);
    chk("ovf_depth", {13'd0, depth},    16'h0004);
    run(PC_RET, 16'h0, 16'h0); chk("oret1", pc_out, 16'h0052);
    run(PC_RET, 16'h0, 16'h0); chk("oret2", pc_out, 16'h0042);
    run(PC_RET, 16'h0, 16'h0); chk("oret3", pc_out, 16'h0032);
    run(PC_RET, 16'h0, 16'h0); chk("oret4", pc_out, 16'h0022);
    run(PC_RET, 16'h0, 16'h0); chk("oret5", pc_out, 16'h0022);
    chk("unf_flag", {15'd0, underflow}, 16'h0001);

    // Reset mid-operation with depth 3 and overflow set.
    for (int i = 0; i < 3; i++) run(PC_CALL, 16'h0, 16'h0400);
    chk("pre_depth", {13'd0, depth}, 16'h0003);
    cyc(1'b0, 1'b1, PC_CALL, 16'h0, 16'h0777);
    chk("mid_rst_pc",    pc_out,              RV);
    chk("mid_rst_depth", {13'd0, depth},      16'h0000);
    chk("mid_rst_ovf",   {15'd0, overflow},   16'h0000);
    chk("mid_rst_unf",   {15'd0, underflow},  16'h0000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic       r, s;
      logic [2:0] o;
      r = ($urandom_range(0, 59) != 0);
      s = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) o = 3'($urandom_range(4, 5));
      else                           o = 3'($urandom_range(0, 7));
      cyc(r, s, o, 16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the accumulator processor datapath; successor to the single 16-bit PC register. Holds the current PC and computes the next one: sequential increment, PC-relative branch, absolute jump, and call/return through an internal return-address stack. Sits between the control unit (which issues `op` and `stall`) and instruction memory (which consumes `pc_out`).

## Interface
- `WIDTH`, 16: PC and address width in bits.
- `INC`, 2: sequential increment (bytes per instruction).
- `RESET_VECTOR`, 0: PC value loaded on reset.
- `STACK_DEPTH`, 4: return-stack entries (≥2, power of two).

- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-low (0 = reset, sampled on rising `clk`).
- `stall` input 1: 1 = freeze all state this cycle, ignore `op`.
- `op` input 3: operation code (see Operation).
- `offset` input WIDTH: signed two's-complement branch displacement.
- `target` input WIDTH: absolute jump/call destination.
- `pc_out` output WIDTH: registered current PC.
- `pc_next` output WIDTH: combinational value `pc_out` takes at the next edge.
- `depth` output $clog2(STACK_DEPTH)+1: valid return-stack entries.
- `overflow` output 1: sticky; set by CALL with stack full.
- `underflow` output 1: sticky; set by RET with stack empty.

## Operation
- Op encodings: HOLD=0, INC=1, BRANCH=2, JUMP=3, CALL=4, RET=5; 6–7 reserved, treated as HOLD.
- Priority per edge: reset > stall > op.
- Reset (`reset`=0): `pc_out`=RESET_VECTOR, `depth`=0, `overflow`=0, `underflow`=0; stack contents don't-care.
- Stall: `pc_out`, stack, `depth`, flags unchanged; `pc_next`=`pc_out`.
- HOLD: `pc_out` unchanged.
- INC: `pc_out` ← `pc_out`+INC, modulo 2^WIDTH.
- BRANCH: `pc_out` ← `pc_out`+`offset`, modulo 2^WIDTH (offset of 0 allowed; wraps both directions).
- JUMP: `pc_out` ← `target`.
- CALL: push `pc_out`+INC (mod 2^WIDTH); `pc_out` ← `target`; `depth`+1. If full: push still occurs, oldest entry overwritten (circular buffer), `depth` stays STACK_DEPTH, `overflow` ← 1.
- RET: `pc_out` ← top entry, pop, `depth`−1. If empty: `pc_out` unchanged, `depth` stays 0, `underflow` ← 1.
- Flags clear only on reset.
- Stack is a circular LIFO: top pointer plus count; push writes top+1, pop reads top and decrements, both modulo STACK_DEPTH.

## Timing
- One-cycle latency: `op` sampled at edge N updates `pc_out` right after edge N.
- `pc_next` is combinational from `pc_out`, `op`, `stall`, `reset`, `offset`, `target`, stack top; valid same cycle; equals RESET_VECTOR while `reset`=0.
- `depth`, `overflow`, `underflow` registered; update on the same edge as `pc_out`.
- Back-to-back CALL/RET every cycle supported; RET immediately after CALL returns the value just pushed.
- Reset asserted mid-sequence takes effect at that edge regardless of `stall`/`op`.
- No combinational path from inputs to `pc_out` or the flags.

## Structure
- Package `pc_pkg`: `pc_op_t` enum (HOLD, INC, BRANCH, JUMP, CALL, RET) and their 3-bit encodings, shared with the control unit.
- Sub-module `return_stack`: parametrised WIDTH/DEPTH circular LIFO with push, pop, top, count, full, empty; synchronous active-low reset clears count/pointer only.
- `pc_unit`: next-PC mux, adder, PC register, flag registers.

## Test plan
- Reset: `reset`=0 for 2 cycles with op=INC → `pc_out`=0x0000, `depth`=0, flags 0; release, 3×INC → 0x0002, 0x0004, 0x0006.
- Branch wrap: PC=0x0004, BRANCH offset=0xFFFA (−6) → 0xFFFE; INC → 0x0000.
- Stall: PC=0x0010, stall=1 with JUMP target=0x1234 for 3 cycles → PC stays 0x0010, `pc_next`=0x0010; stall=0 → 0x1234.
- Call/return: at PC=0x0100, CALL 0x0200, then CALL 0x0300, RET, RET → PCs 0x0200, 0x0300, 0x0202, 0x0102; `depth` 1,2,1,0.
- Overflow: STACK_DEPTH=4, 5 CALLs from PCs 0x10,0x20,0x30,0x40,0x50 → `overflow`=1, `depth`=4; 4 RETs yield 0x52,0x42,0x32,0x22; 5th RET → PC unchanged, `underflow`=1.
- Reset mid-operation: `depth`=3, `overflow`=1, assert `reset`=0 with op=CALL, stall=1 → next cycle PC=RESET_VECTOR, `depth`=0, flags 0.
